// File: rtl/axi_defs.sv
// AXI SRAM slave shared definitions.
// Response and burst codes plus the transaction FSM states.
package axi_defs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDATA,
    WDATA,
    WRESP
  } state_t;

endpackage

// File: rtl/axi_sram_slave_mem.sv
// Single-port word array with byte enables.
// Read data is registered and only changes on an enabled access.
module axi_sram_slave_mem #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI slave fronting a synchronous SRAM.
// Serves one read or write burst at a time; writes win ties.
module axi_sram_slave
  import axi_defs::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  state_t      state_q, state_d;
  logic [32:0] addr_q;
  logic [32:0] next_addr;
  logic [32:0] off;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic        fixed_q;
  logic        err_q;
  logic [3:0]  rid_q, bid_q;
  logic        oor;
  logic        last;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        unused;

  // 33-bit address so an INCR run past 2^32 stays out of range
  assign off       = addr_q - {1'b0, BASE_ADDR};
  assign oor       = |off[32:ADDR_WIDTH+2];
  assign next_addr = fixed_q ? addr_q : addr_q + 33'd4;
  assign last      = (beat_q == len_q);

  assign unused = ^{arsize, arlock, arcache, arprot, awsize,
                    awlock, awcache, awprot, wid, wlast, off[1:0]};

  axi_sram_slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (off[ADDR_WIDTH+1:2]),
    .wdata(wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 4'b0;
    unique case (state_q)
      IDLE: begin
        awready = 1'b1;
        arready = ~awvalid;
        if (awvalid)      state_d = WDATA;
        else if (arvalid) state_d = RD;
      end
      RD: begin
        mem_en  = ~oor;
        state_d = RDATA;
      end
      RDATA: begin
        rvalid = 1'b1;
        if (rready) state_d = last ? IDLE : RD;
      end
      WDATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_en = ~oor;
          mem_we = wstrb & {4{~oor}};
          if (last) state_d = WRESP;
        end
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rid   = rid_q;
  assign bid   = bid_q;
  assign rdata = (rvalid && !oor) ? mem_rdata : 32'd0;
  assign rresp = (rvalid && oor) ? SLVERR : OKAY;
  assign rlast = rvalid && last;
  assign bresp = (bvalid && err_q) ? SLVERR : OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      rid_q   <= '0;
      bid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && awvalid) begin
        addr_q  <= {1'b0, awaddr};
        len_q   <= {4'd0, awlen};
        fixed_q <= (awburst == FIXED);
        bid_q   <= awid;
        beat_q  <= '0;
        err_q   <= 1'b0;
      end else if (state_q == IDLE && arvalid) begin
        addr_q  <= {1'b0, araddr};
        len_q   <= arlen;
        fixed_q <= (arburst == FIXED);
        rid_q   <= arid;
        beat_q  <= '0;
      end else if (state_q == RDATA && rready && !last) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= next_addr;
      end else if (state_q == WDATA && wvalid) begin
        err_q  <= err_q | oor;
        beat_q <= beat_q + 8'd1;
        addr_q <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized and directed bench for axi_sram_slave.
// A word-array reference model predicts every beat and response.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam longint      WIN  = 4 * 4096;

  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  arid = 0, awid = 0;
  logic [31:0] araddr = 0, awaddr = 0;
  logic [7:0]  arlen = 0;
  logic [3:0]  awlen = 0;
  logic [1:0]  arburst = 0, awburst = 0;
  logic        arvalid = 0, awvalid = 0;
  logic        rready = 0, wvalid = 0, wlast = 0, bready = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        arready, awready, rvalid, rlast, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [4096];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] last_rdata;
  logic [1:0]  wresp;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2),
    .arburst(arburst), .arlock(2'd0), .arcache(4'd0), .arprot(3'd0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2),
    .awburst(awburst), .awlock(2'd0), .awcache(4'd0), .awprot(3'd0),
    .awvalid(awvalid), .awready(awready),
    .wid(4'd0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint baddr(input logic [31:0] a,
                                   input logic [1:0] burst, input int i);
    longint b;
    b = {32'd0, a};
    if (burst == 2'b00) return b;
    return b + 4 * i;
  endfunction

  function automatic bit inr(input longint a);
    return a >= {32'd0, BASE} && a < {32'd0, BASE} + WIN;
  endfunction

  function automatic int widx(input longint a);
    return int'((a - {32'd0, BASE}) >> 2) % 4096;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len,
                             input logic [1:0] burst,
                             output logic [1:0] resp);
    longint a;
    int w;
    resp = 2'b00;
    for (int i = 0; i <= len; i++) begin
      a = baddr(addr, burst, i);
      if (!inr(a)) resp = 2'b10;
      else begin
        w = widx(a);
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) model[w][8*b +: 8] = wbuf[i][8*b +: 8];
      end
    end
  endtask

  task automatic aw_phase(input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [3:0] id);
    logic h;
    awaddr = addr; awlen = 4'(len); awburst = burst; awid = id;
    awvalid = 1;
    h = 0;
    for (int k = 0; k < 20 && !h; k++) begin
      #1;
      h = awready;
      tick();
    end
    awvalid = 0;
    check("aw_handshake", h, 1);
  endtask

  task automatic w_phase(input int len);
    logic h;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 0;
        tick();
      end
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len);
      wvalid = 1;
      h = 0;
      for (int k = 0; k < 20 && !h; k++) begin
        #1;
        h = wready;
        tick();
      end
      check("w_handshake", h, 1);
    end
    wvalid = 0; wlast = 0;
  endtask

  task automatic b_phase(input logic [3:0] id, input logic [1:0] exp);
    for (int k = 0; k < 20 && !bvalid; k++) tick();
    check("b_valid", bvalid, 1);
    check("b_id", bid, id);
    check("b_resp", bresp, exp);
    repeat ($urandom_range(0, 2)) tick();
    check("b_hold", bvalid, 1);
    bready = 1;
    tick();
    bready = 0;
    check("b_done", bvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [3:0] id);
    logic [1:0] resp;
    model_write(addr, len, burst, resp);
    wresp = resp;
    aw_phase(addr, len, burst, id);
    w_phase(len);
    b_phase(id, resp);
  endtask

  task automatic ar_phase(input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [3:0] id);
    logic h;
    araddr = addr; arlen = 8'(len); arburst = burst; arid = id;
    arvalid = 1;
    h = 0;
    for (int k = 0; k < 20 && !h; k++) begin
      #1;
      h = arready;
      tick();
    end
    arvalid = 0;
    check("ar_handshake", h, 1);
    check("r_latency_n1", rvalid, 0);
    tick();
    check("r_latency_n2", rvalid, 1);
  endtask

  task automatic r_phase(input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [3:0] id,
                         input int mode);
    longint a;
    logic [31:0] ed;
    logic [1:0] er;
    logic rr, tog;
    tog = 1;
    for (int i = 0; i <= len; i++) begin
      for (int k = 0; k < 20 && !rvalid; k++) tick();
      check("r_valid", rvalid, 1);
      a = baddr(addr, burst, i);
      ed = inr(a) ? model[widx(a)] : 32'd0;
      er = inr(a) ? 2'b00 : 2'b10;
      rr = 0;
      for (int k = 0; k < 8 && !rr; k++) begin
        check("r_data", rdata, ed);
        check("r_resp", rresp, er);
        check("r_id", rid, id);
        check("r_last", rlast, i == len);
        case (mode)
          0: rr = 1;
          1: begin rr = tog; tog = ~tog; end
          default: rr = 1'($urandom_range(0, 1));
        endcase
        if (k == 7) rr = 1;
        last_rdata = rdata;
        rready = rr;
        tick();
        rready = 0;
      end
    end
    check("r_done", rvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [3:0] id,
                         input int mode);
    ar_phase(addr, len, burst, id);
    r_phase(addr, len, burst, id, mode);
  endtask

  initial begin
    logic [31:0] a;
    int len;
    logic [1:0] bu;
    logic [3:0] id;

    // reset state
    repeat (3) tick();
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    rst = 0;
    #1;
    check("rel_arready", arready, 1);
    check("rel_awready", awready, 1);

    // prefill words 0..63
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = $urandom; sbuf[i] = 4'hF;
      end
      do_write(BASE + 32'(64 * b), 15, 2'b01, 4'(b));
    end

    // single read
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(BASE + 32'h10, 0, 2'b01, 4'd1);
    do_read(BASE + 32'h10, 0, 2'b01, 4'd3, 0);
    check("single_rdata", last_rdata, 32'hDEADBEEF);

    // byte-lane write
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
    do_write(BASE + 32'h20, 0, 2'b01, 4'd2);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
    do_write(BASE + 32'h20, 0, 2'b01, 4'd7);
    check("strb_bresp", wresp, 0);
    do_read(BASE + 32'h20, 0, 2'b01, 4'd4, 0);
    check("strb_rdata", last_rdata, 32'hAA22CC44);

    // INCR burst with rready 1-0-1
    do_read(BASE + 32'h40, 3, 2'b01, 4'd9, 1);

    // write wins a tie
    wbuf[0] = $urandom; sbuf[0] = 4'hF;
    model_write(BASE + 32'h30, 0, 2'b01, wresp);
    araddr = BASE + 32'h30; arlen = 0; arburst = 2'b01; arid = 4'd5;
    awaddr = BASE + 32'h30; awlen = 0; awburst = 2'b01; awid = 4'd6;
    arvalid = 1; awvalid = 1;
    #1;
    check("tie_arready", arready, 0);
    check("tie_awready", awready, 1);
    tick();
    awvalid = 0;
    w_phase(0);
    b_phase(4'd6, 2'b00);
    do_read(BASE + 32'h30, 0, 2'b01, 4'd5, 0);
    check("tie_rdata", last_rdata, wbuf[0]);

    // out of range
    do_read(BASE + 32'h10000, 0, 2'b01, 4'd1, 0);
    wbuf[0] = 32'h5A5A5A5A; sbuf[0] = 4'hF;
    do_write(BASE + 32'h10000, 0, 2'b01, 4'd8);
    check("oor_bresp", wresp, 2'b10);
    do_read(BASE, 1, 2'b01, 4'd2, 0);
    do_read(BASE - 32'd4, 0, 2'b01, 4'd3, 0);

    // INCR across the top of the window
    wbuf[0] = $urandom; wbuf[1] = $urandom; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(BASE + 32'(WIN - 8), 1, 2'b01, 4'd1);
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom; sbuf[i] = 4'hF;
    end
    do_write(BASE + 32'(WIN - 8), 3, 2'b01, 4'd2);
    check("top_bresp", wresp, 2'b10);
    do_read(BASE + 32'(WIN - 8), 3, 2'b01, 4'd3, 2);
    do_read(BASE, 3, 2'b01, 4'd4, 0);

    // FIXED bursts
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom; sbuf[i] = 4'(1 << i);
    end
    do_write(BASE + 32'h30, 3, 2'b00, 4'd5);
    do_read(BASE + 32'h30, 2, 2'b00, 4'd6, 2);

    // reset mid-burst
    ar_phase(BASE + 32'h40, 3, 2'b01, 4'd10);
    rready = 1;
    tick();
    rready = 0;
    for (int k = 0; k < 20 && !rvalid; k++) tick();
    check("mid_beat2", rvalid, 1);
    rst = 1;
    #1;
    check("mid_rvalid", rvalid, 0);
    check("mid_rlast", rlast, 0);
    tick();
    rst = 0;
    #1;
    check("mid_arready", arready, 1);
    do_read(BASE + 32'h10, 0, 2'b01, 4'd3, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 7);
      bu = 2'($urandom_range(0, 3));
      id = 4'($urandom);
      if ($urandom_range(0, 5) == 0)
        a = ($urandom_range(0, 1) != 0)
            ? BASE + 32'(WIN) + 32'(4 * $urandom_range(0, 15))
            : BASE - 32'(4 * $urandom_range(1, 16));
      else
        a = BASE + 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) begin
        for (int i = 0; i <= len; i++) begin
          wbuf[i] = $urandom; sbuf[i] = 4'($urandom);
        end
        do_write(a, len, bu, id);
      end else begin
        do_read(a, len, bu, id, $urandom_range(0, 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12; word-index bits, giving a 4096-word (16 KiB) array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000; byte base of the decoded window.
REQ-003 SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-005 arid input 4, arsize input 3, arburst input 2 and arlen input 8 form the read request; arlock, arcache and arprot are inputs and are ignored.
REQ-006 araddr input 32, read byte address; arvalid input 1; arready output 1.
REQ-007 rid output 4, rdata output 32, rresp output 2, rlast output 1, rvalid output 1; rready input 1.
REQ-008 awid input 4, awaddr input 32, awlen input 4, awsize input 3, awburst input 2; awlock, awcache and awprot are inputs and are ignored.
REQ-009 awvalid input 1; awready output 1; wid input 4 (ignored); wdata input 32; wstrb input 4; wlast input 1 (ignored); wvalid input 1; wready output 1.
REQ-010 bid output 4, bresp output 2, bvalid output 1; bready input 1.

Function
REQ-011 SHALL serve one transaction at a time with FSM states IDLE, RD, RDATA, WDATA, WRESP.
REQ-012 IDLE: awready=1; arready=~awvalid. If both valids are high in the same cycle, the write wins.
REQ-013 AR handshake SHALL capture id, addr, len and burst, then go to RD. RD reads the array for one cycle, then goes to RDATA.
REQ-014 RDATA: rvalid=1, and rdata/rresp/rlast are held stable until rready. Minimum latency is AR handshake at cycle N -> rvalid at N+2.
REQ-015 On an R handshake that is not the last beat: beat counter +1, go to RD. On the last beat: go to IDLE.
REQ-016 rlast SHALL be 1 only when the beat count equals the captured arlen; rid SHALL equal the captured arid for every beat.
REQ-017 AW handshake SHALL capture id, addr, len and burst, then go to WDATA.
REQ-018 WDATA: wready=1. Each W handshake writes bytes lane i where wstrb[i]=1; after beat awlen, go to WRESP.
REQ-019 WRESP: bvalid=1, bid=captured awid; hold until bready, then go to IDLE.
REQ-020 Burst addressing: arburst/awburst 2'b01 (INCR) adds 4 per beat; 2'b00 (FIXED) holds the address. Any other burst code SHALL be treated as INCR.
REQ-021 Word index SHALL be (addr-BASE_ADDR)[ADDR_WIDTH+1:2]; addr[1:0] and arsize/awsize are ignored (full-word lanes).
REQ-022 A beat whose address falls outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH) is out of range:
- read beat: rresp=2'b10 (SLVERR), rdata=0
- write beat: no array write; bresp SHALL be SLVERR if any beat in the burst was out of range, else 2'b00.
- INCR wrap past the top SHALL yield SLVERR, not wrap-around.
REQ-023 A write-then-read to the same word SHALL return the new data, guaranteed by serialization.

Reset
REQ-024 On rst: state=IDLE; rvalid, bvalid and wready =0; rresp, bresp, rid, bid, rdata and rlast =0; counters cleared.
REQ-025 Reset SHALL abort any in-flight transaction without completing it; array contents are not reset.
REQ-026 After rst deasserts, arready/awready SHALL follow REQ-012 in the first cycle.

Structure
REQ-027 Shared package axi_defs SHALL hold:
- resp codes OKAY=2'b00, SLVERR=2'b10
- burst codes FIXED=2'b00, INCR=2'b01
- the FSM state enumeration.
REQ-028 Sub-module axi_sram_slave_mem SHALL be the single-port, byte-enabled, 1-cycle synchronous-read array; the FSM lives in the top module.

Verification
REQ-029 Single read: preload word 0x10 = 0xDEADBEEF; AR addr 0x10, len 0, id 3 -> rvalid at N+2, rdata 0xDEADBEEF, rid 3, rlast 1, rresp 0.
REQ-030 Byte write: write 0x11223344 to 0x20 with wstrb 4'b0101 over old 0xAABBCCDD -> bresp 0; readback 0xAA22CC44.
REQ-031 INCR read burst: len 3 from 0x40 with rready toggled 1-0-1 -> 4 beats from 0x40/44/48/4C, data stable while stalled, rlast only on beat 4.
REQ-032 Simultaneous arvalid and awvalid in IDLE -> write accepted first (arready=0 that cycle); the subsequent read returns the written data.
REQ-033 Out of range: read at BASE_ADDR+0x10000 -> rresp 2'b10, rdata 0; write there -> bresp 2'b10 and the array is unchanged.
REQ-034 Reset mid-burst: assert rst during beat 2 of a len-3 read -> rvalid 0 immediately, IDLE on release; the next single read completes normally.
